// File: rtl/cadence_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cadence_pkg : default constants and averaging step for cadence_chan   |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
package cadence_pkg;

  localparam int DEF_N_CH      = 1;
  localparam int DEF_FILT_LEN  = 16;
  localparam int DEF_PER_W     = 16;
  localparam int DEF_AVG_SHIFT = 2;
  localparam int DEF_TIMEOUT   = 50000;

  // (avg*(2^shift-1) + sample) >> shift, floored. The true intermediate never
  // exceeds PER_W+AVG_SHIFT bits, so doing the math wide gives identical results.
  function automatic logic [31:0] avg_step(input logic [31:0] avg,
                                           input logic [31:0] sample,
                                           input int unsigned shift);
    logic [63:0] a64;
    logic [63:0] acc;
    logic [63:0] res;
    a64 = {32'd0, avg};
    acc = (a64 << shift) - a64 + {32'd0, sample};
    res = acc >> shift;
    return res[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cadence_chan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cadence_chan : sync, debounce, edge qualify, period average, flags    |
// | Revision     : 1.0                                                    |
// +-----------------------------------------------------------------------+
module cadence_chan
  import cadence_pkg::*;
#(
  parameter int FILT_LEN  = DEF_FILT_LEN,
  parameter int PER_W     = DEF_PER_W,
  parameter int AVG_SHIFT = DEF_AVG_SHIFT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_i,
  input  logic             edge_mode_i,
  input  logic             disarm_i,
  output logic             filt_o,
  output logic             edge_stb_o,
  output logic [PER_W-1:0] period_avg_o,
  output logic             valid_o,
  output logic             stalled_o
);

  localparam int DB_W = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(FILT_LEN - 1);
  localparam logic [PER_W-1:0] CNT_MAX = '1;
  localparam logic [PER_W-1:0] TOUT    = PER_W'(TIMEOUT);

  logic             sync1_q, sync2_q;
  logic [DB_W-1:0]  db_q, db_d;
  logic             filt_q, filt_d;
  logic             stb_q, stb_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] avg_q, avg_d;
  logic             armed_q, armed_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;

  logic             w_diff, w_toggle, w_edge;
  logic [PER_W-1:0] w_sample;
  logic [31:0]      w_avg_step;

  always_comb begin
    w_diff     = (sync2_q != filt_q);
    w_toggle   = w_diff && (db_q == DB_LAST);
    // filt_q still holds the old level, so a rising edge has filt_q == 0
    w_edge     = w_toggle && (edge_mode_i || !filt_q);
    w_sample   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    w_avg_step = avg_step(32'(avg_q), 32'(w_sample), AVG_SHIFT);

    db_d      = w_diff ? (w_toggle ? '0 : db_q + 1'b1) : '0;
    filt_d    = filt_q ^ w_toggle;
    stb_d     = w_edge;
    cnt_d     = w_edge ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    armed_d   = armed_q;
    valid_d   = valid_q;
    stalled_d = stalled_q;
    avg_d     = avg_q;

    if (w_edge && !disarm_i) begin
      if (!armed_q) begin
        armed_d = 1'b1;
      end else if (!valid_q) begin
        avg_d     = w_sample;
        valid_d   = 1'b1;
        stalled_d = 1'b0;
      end else begin
        avg_d = w_avg_step[PER_W-1:0];
      end
    end
    if (!w_edge && (cnt_q == TOUT)) begin
      stalled_d = 1'b1;
      valid_d   = 1'b0;
      armed_d   = 1'b0;
    end
    if (disarm_i) begin
      armed_d = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= '0;
      filt_q    <= 1'b0;
      stb_q     <= 1'b0;
      cnt_q     <= '0;
      avg_q     <= '0;
      armed_q   <= 1'b0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b1;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      filt_q    <= filt_d;
      stb_q     <= stb_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      armed_q   <= armed_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
  end

  assign filt_o       = filt_q;
  assign edge_stb_o   = stb_q;
  assign period_avg_o = avg_q;
  assign valid_o      = valid_q;
  assign stalled_o    = stalled_q;

endmodule
`default_nettype wire

// File: rtl/cadence_period_meas.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cadence_period_meas : N_CH cadence channels with shared edge mode     |
// | Revision            : 1.0                                             |
// +-----------------------------------------------------------------------+
module cadence_period_meas
  import cadence_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int FILT_LEN  = DEF_FILT_LEN,
  parameter int PER_W     = DEF_PER_W,
  parameter int AVG_SHIFT = DEF_AVG_SHIFT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       raw,
  input  logic                  edge_mode,
  output logic [N_CH-1:0]       filt,
  output logic [N_CH-1:0]       edge_stb,
  output logic [N_CH*PER_W-1:0] period_avg,
  output logic [N_CH-1:0]       valid,
  output logic [N_CH-1:0]       stalled
);

  logic mode_q;
  logic w_disarm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= 1'b0;
    else        mode_q <= edge_mode;
  end

  // Any mode change invalidates in-flight periods on every channel
  assign w_disarm = (edge_mode != mode_q);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    cadence_chan #(
      .FILT_LEN (FILT_LEN),
      .PER_W    (PER_W),
      .AVG_SHIFT(AVG_SHIFT),
      .TIMEOUT  (TIMEOUT)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_i       (raw[k]),
      .edge_mode_i (edge_mode),
      .disarm_i    (w_disarm),
      .filt_o      (filt[k]),
      .edge_stb_o  (edge_stb[k]),
      .period_avg_o(period_avg[k*PER_W +: PER_W]),
      .valid_o     (valid[k]),
      .stalled_o   (stalled[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_cadence_period_meas.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cadence_period_meas : directed bench, 2 channels, short timeout    |
// | Revision               : 1.0                                          |
// +-----------------------------------------------------------------------+
module tb_cadence_period_meas;

  localparam int N_CH = 2, FILT_LEN = 4, PER_W = 12, AVG_SHIFT = 2, TIMEOUT = 1000;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  raw0 = 1'b0, raw1 = 1'b0;
  logic [N_CH-1:0]       raw;
  logic                  edge_mode = 1'b0;
  logic [N_CH-1:0]       filt, edge_stb, valid, stalled;
  logic [N_CH*PER_W-1:0] period_avg;

  int n_chk = 0;
  int n_err = 0;

  assign raw = {raw1, raw0};
  always #5 clk = ~clk;

  cadence_period_meas #(
    .N_CH(N_CH), .FILT_LEN(FILT_LEN), .PER_W(PER_W),
    .AVG_SHIFT(AVG_SHIFT), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .raw(raw), .edge_mode(edge_mode),
    .filt(filt), .edge_stb(edge_stb), .period_avg(period_avg),
    .valid(valid), .stalled(stalled)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are read 1 ns after posedge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] avg0();
    return 32'(period_avg[PER_W-1:0]);
  endfunction

  initial begin
    int exp_avg [3] = '{180, 165, 153};
    int seen;

    step(5);
    chk("rst_stalled", 32'(stalled), 32'd3);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_avg", 32'(period_avg), 32'd0);
    chk("rst_filt", 32'(filt), 32'd0);
    chk("rst_stb", 32'(edge_stb), 32'd0);
    rst_n = 1'b1;
    step(2);

    // First rise: arms only, strobe after 2 sync + FILT_LEN clocks
    raw0 = 1'b1;
    step(5);
    chk("stb_early", 32'(edge_stb[0]), 32'd0);
    step(1);
    chk("stb_first", 32'(edge_stb[0]), 32'd1);
    chk("filt_first", 32'(filt[0]), 32'd1);
    chk("arm_no_valid", 32'(valid[0]), 32'd0);
    step(1);
    chk("stb_one_cycle", 32'(edge_stb[0]), 32'd0);
    step(93);
    raw0 = 1'b0;
    step(6);
    chk("fall_filt", 32'(filt[0]), 32'd0);
    chk("fall_no_stb", 32'(edge_stb[0]), 32'd0);
    step(94);
    raw0 = 1'b1;
    step(6);
    chk("seed_stb", 32'(edge_stb[0]), 32'd1);
    chk("seed_avg", avg0(), 32'd200);
    chk("seed_valid", 32'(valid[0]), 32'd1);
    chk("seed_stalled", 32'(stalled[0]), 32'd0);
    chk("ch1_valid", 32'(valid[1]), 32'd0);
    chk("ch1_stalled", 32'(stalled[1]), 32'd1);

    // Period 120: 200 -> 180 -> 165 -> 153
    for (int i = 0; i < 3; i++) begin
      step(54);
      raw0 = 1'b0;
      step(60);
      raw0 = 1'b1;
      step(6);
      chk($sformatf("avg120_%0d", i), avg0(), 32'(exp_avg[i]));
    end

    // ch0 now holds high; meanwhile a 3-clock glitch on ch1
    raw1 = 1'b1;
    step(3);
    raw1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen += int'(filt[1]) + int'(edge_stb[1]);
    end
    chk("glitch_ch1", 32'(seen), 32'd0);
    step(1000 - 15);
    chk("pre_stall", 32'(stalled[0]), 32'd0);
    chk("pre_stall_valid", 32'(valid[0]), 32'd1);
    step(1);
    chk("stall", 32'(stalled[0]), 32'd1);
    chk("stall_valid", 32'(valid[0]), 32'd0);
    chk("stall_avg_hold", avg0(), 32'd153);

    // Restart: first rise arms only, second seeds
    raw0 = 1'b0;
    step(100);
    raw0 = 1'b1;
    step(6);
    chk("rearm_stb", 32'(edge_stb[0]), 32'd1);
    chk("rearm_avg", avg0(), 32'd153);
    chk("rearm_valid", 32'(valid[0]), 32'd0);
    chk("rearm_stalled", 32'(stalled[0]), 32'd1);
    step(94);
    raw0 = 1'b0;
    step(100);
    raw0 = 1'b1;
    step(6);
    chk("reseed_avg", avg0(), 32'd200);
    chk("reseed_valid", 32'(valid[0]), 32'd1);

    // Switch to both-edge mode
    edge_mode = 1'b1;
    step(1);
    chk("mode_valid", 32'(valid[0]), 32'd0);
    chk("mode_stalled", 32'(stalled[0]), 32'd0);
    chk("mode_avg_hold", avg0(), 32'd200);
    step(93);
    raw0 = 1'b0;
    step(6);
    chk("both_fall_stb", 32'(edge_stb[0]), 32'd1);
    chk("both_arm_valid", 32'(valid[0]), 32'd0);
    step(94);
    raw0 = 1'b1;
    step(6);
    chk("both_avg", avg0(), 32'd100);
    chk("both_valid", 32'(valid[0]), 32'd1);

    // Long hold: counter saturates, channel stalls
    step(5000);
    chk("sat_stalled", 32'(stalled[0]), 32'd1);
    chk("sat_cnt", 32'(u_dut.g_ch[0].u_chan.cnt_q), 32'd4095);

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_filt", 32'(filt), 32'd0);
    chk("async_rst_stalled", 32'(stalled), 32'd3);
    chk("async_rst_avg", 32'(period_avg), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
